// File: rtl/snake_head_if.sv
// Snake head controller bus: direction buttons and game events in, head state out.
// The slave modport is the controller; master is whatever drives the buttons.
interface snake_head_if;
    logic       btn_L, btn_R, btn_U, btn_D;
    logic       hit_score;
    logic       self_hit;
    logic       L, R, U, D;
    logic       tracking;
    logic [2:0] head_x, head_y;
    logic [5:0] snake_length;
    logic       gameover;

    modport slave (
        input  btn_L, btn_R, btn_U, btn_D, hit_score, self_hit,
        output L, R, U, D, tracking, head_x, head_y, snake_length, gameover
    );

    modport master (
        output btn_L, btn_R, btn_U, btn_D, hit_score, self_hit,
        input  L, R, U, D, tracking, head_x, head_y, snake_length, gameover
    );
endinterface

// File: rtl/snake_head_ctrl.sv
// Snake head controller for an 8x8 matrix: direction latch, step timer, head position, length.
// Define SNAKE_WRAP_EN to wrap at grid edges; otherwise leaving the grid ends the game.
module snake_head_ctrl #(
    parameter int TICK_DIV = 25000000
) (
    input  logic         Clock,
    input  logic         reset,
    snake_head_if.slave  bus
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    // One-hot direction encoding {U, D, L, R}
    localparam logic [3:0] DIR_U = 4'b1000;
    localparam logic [3:0] DIR_D = 4'b0100;
    localparam logic [3:0] DIR_L = 4'b0010;
    localparam logic [3:0] DIR_R = 4'b0001;

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t        state, state_nxt;
    logic [3:0]    dir, dir_nxt;
    logic [3:0]    pend, pend_nxt;
    logic [3:0]    req;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    hx, hy, hx_nxt, hy_nxt;
    logic [2:0]    mx, my;
    logic [5:0]    len, len_nxt;
    logic          trk, trk_nxt;
    logic          step;

    function automatic logic is_opp(input logic [3:0] a, input logic [3:0] b);
        return (a[3] & b[2]) | (a[2] & b[3]) | (a[1] & b[0]) | (a[0] & b[1]);
    endfunction

    always_comb begin
        req = 4'b0000;
        if      (bus.btn_U) req = DIR_U;
        else if (bus.btn_D) req = DIR_D;
        else if (bus.btn_L) req = DIR_L;
        else if (bus.btn_R) req = DIR_R;
    end

    // A press made on the step cycle itself still steers that step
    always_comb begin
        pend_nxt = pend;
        if (req != 4'b0000 && !is_opp(req, dir))
            pend_nxt = req;
    end

    assign step = (cnt == TERM);

    // 3-bit arithmetic wraps modulo 8 on its own
    always_comb begin
        mx = hx;
        my = hy;
        case (pend_nxt)
            DIR_R:   mx = hx + 3'd1;
            DIR_L:   mx = hx - 3'd1;
            DIR_D:   my = hy + 3'd1;
            DIR_U:   my = hy - 3'd1;
            default: ;
        endcase
    end

`ifndef SNAKE_WRAP_EN
    logic off_edge;
    always_comb begin
        off_edge = 1'b0;
        case (pend_nxt)
            DIR_R:   off_edge = (hx == 3'd7);
            DIR_L:   off_edge = (hx == 3'd0);
            DIR_D:   off_edge = (hy == 3'd7);
            DIR_U:   off_edge = (hy == 3'd0);
            default: ;
        endcase
    end
`endif

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        hx_nxt    = hx;
        hy_nxt    = hy;
        len_nxt   = len;
        trk_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt = RUN;
                    dir_nxt   = req;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                cnt_nxt = step ? '0 : cnt + 1'b1;
                if (bus.hit_score && len != 6'd63)
                    len_nxt = len + 6'd1;
                if (bus.self_hit) begin
                    state_nxt = OVER;
                end else if (step) begin
                    dir_nxt = pend_nxt;
`ifdef SNAKE_WRAP_EN
                    hx_nxt  = mx;
                    hy_nxt  = my;
                    trk_nxt = 1'b1;
`else
                    if (off_edge) begin
                        state_nxt = OVER;
                    end else begin
                        hx_nxt  = mx;
                        hy_nxt  = my;
                        trk_nxt = 1'b1;
                    end
`endif
                end
            end
            OVER:    ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state <= IDLE;
            dir   <= DIR_R;
            pend  <= DIR_R;
            cnt   <= '0;
            hx    <= 3'd3;
            hy    <= 3'd4;
            len   <= 6'd2;
            trk   <= 1'b0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            // IDLE entry seeds pending with the accepted button; OVER freezes it
            if (state == IDLE && req != 4'b0000) pend <= req;
            else if (state == RUN)               pend <= pend_nxt;
            cnt   <= cnt_nxt;
            hx    <= hx_nxt;
            hy    <= hy_nxt;
            len   <= len_nxt;
            trk   <= trk_nxt;
        end
    end

    assign bus.U            = dir[3];
    assign bus.D            = dir[2];
    assign bus.L            = dir[1];
    assign bus.R            = dir[0];
    assign bus.tracking     = trk;
    assign bus.head_x       = hx;
    assign bus.head_y       = hy;
    assign bus.snake_length = len;
    assign bus.gameover     = (state == OVER);

endmodule
